// File: rtl/fwd_source_tracker_if.sv
// ---------------------------------------------------------------------------
// fwd_source_tracker_if
// Bundles the issue handshake, the execute/memory result inputs and the
// forwarding/writeback outputs of the forwarding-source tracker.
//   master : issue stage / test driver side (drives issue + result inputs)
//   slave  : tracker side (drives iss_ready, fwd_* and wb_*)
// Signals:
//   iss_valid, iss_ready, iss_inst   instruction issue handshake into X
//   ex_result                        ALU/PC result of the X-stage instruction
//   mem_rdata_vld, mem_rdata         load data return
//   fwd_valid, fwd_rd, fwd_data      W-stage forwarding source
//   wb_en, wb_rd, wb_data            register-file write port
// ---------------------------------------------------------------------------
interface fwd_source_tracker_if;
    logic        iss_valid;
    logic        iss_ready;
    logic [31:0] iss_inst;
    logic [31:0] ex_result;
    logic        mem_rdata_vld;
    logic [31:0] mem_rdata;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    modport master (
        output iss_valid, iss_inst, ex_result, mem_rdata_vld, mem_rdata,
        input  iss_ready, fwd_valid, fwd_rd, fwd_data, wb_en, wb_rd, wb_data
    );

    modport slave (
        input  iss_valid, iss_inst, ex_result, mem_rdata_vld, mem_rdata,
        output iss_ready, fwd_valid, fwd_rd, fwd_data, wb_en, wb_rd, wb_data
    );
endinterface

// File: rtl/fwd_source_tracker.sv
// ---------------------------------------------------------------------------
// fwd_source_tracker
// Producer side of the rs1/rs2 forwarding path. Tracks instructions through
// the execute (X) and writeback (W) stages, captures rd and result of each,
// publishes the W-stage result as a forwarding source and drives register
// file writeback. A load in X moves to W and interlocks the pipeline until
// memory returns data, or until a bounded wait forces completion with zero.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        kill the X-stage instruction / drop the one being issued
//   bus          issue handshake, result inputs, fwd_* and wb_* outputs
//   stall        upstream of X must hold (load wait in progress)
//   ld_timeout   one-cycle pulse in the final wait cycle of a forced completion
//   stall_cnt    saturating count of load-wait cycles
// ---------------------------------------------------------------------------
module fwd_source_tracker #(
    parameter int LD_TIMEOUT = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    fwd_source_tracker_if.slave   bus,
    output logic                  stall,
    output logic                  ld_timeout,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int              WC_W    = (LD_TIMEOUT > 1) ? $clog2(LD_TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(LD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_RUN     = 1'b0,
        ST_LD_WAIT = 1'b1
    } state_t;

    state_t            state_r;
    logic [WC_W-1:0]   wait_cnt_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    // X stage
    logic              x_valid_r;
    logic [4:0]        x_rd_r;
    logic              x_we_r;
    logic              x_is_load_r;

    // W stage
    logic              w_valid_r;
    logic [4:0]        w_rd_r;
    logic              w_we_r;
    logic              w_rdy_r;
    logic [31:0]       w_data_r;

    logic [6:0]        iss_op_s;
    logic [4:0]        iss_rd_s;
    logic              iss_we_s;
    logic              iss_is_load_s;
    logic              issue_s;
    logic              timeout_s;
    logic              fwd_valid_s;
    logic              unused_inst_s;

    // Instruction decode and the issue / forced-completion conditions.
    always_comb begin
        iss_op_s      = bus.iss_inst[6:0];
        iss_rd_s      = bus.iss_inst[11:7];
        iss_we_s      = (iss_op_s != OPC_BRANCH) && (iss_op_s != OPC_STORE) && (iss_rd_s != 5'd0);
        iss_is_load_s = (iss_op_s == OPC_LOAD);
        // Issue is only accepted while running; a flush drops it outright.
        issue_s       = bus.iss_valid && (state_r == ST_RUN) && !flush;
        // Last permitted wait cycle with no data: complete the load with zero.
        timeout_s     = (state_r == ST_LD_WAIT) && !bus.mem_rdata_vld && (wait_cnt_r == WC_LAST);
    end

    // Upper instruction bits carry no information this block needs.
    assign unused_inst_s = ^bus.iss_inst[31:12];

    // Pipeline FSM: stage registers, load interlock, wait and stall counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_RUN;
            wait_cnt_r  <= {WC_W{1'b0}};
            stall_cnt_r <= {CNT_W{1'b0}};
            x_valid_r   <= 1'b0;
            x_rd_r      <= 5'd0;
            x_we_r      <= 1'b0;
            x_is_load_r <= 1'b0;
            w_valid_r   <= 1'b0;
            w_rd_r      <= 5'd0;
            w_we_r      <= 1'b0;
            w_rdy_r     <= 1'b0;
            w_data_r    <= 32'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    // W always takes X; a load enters W not ready.
                    w_valid_r <= x_valid_r;
                    w_rd_r    <= x_rd_r;
                    w_we_r    <= x_we_r;
                    w_rdy_r   <= !x_is_load_r;
                    w_data_r  <= bus.ex_result;
                    if (issue_s) begin
                        x_valid_r   <= 1'b1;
                        x_rd_r      <= iss_rd_s;
                        x_we_r      <= iss_we_s;
                        x_is_load_r <= iss_is_load_s;
                    end else begin
                        x_valid_r   <= 1'b0;
                        x_rd_r      <= 5'd0;
                        x_we_r      <= 1'b0;
                        x_is_load_r <= 1'b0;
                    end
                    wait_cnt_r <= {WC_W{1'b0}};
                    if (x_valid_r && x_is_load_r) begin
                        state_r <= ST_LD_WAIT;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_LD_WAIT: begin
                    // X and W hold, except that a flush still kills X.
                    if (flush) begin
                        x_valid_r   <= 1'b0;
                        x_rd_r      <= 5'd0;
                        x_we_r      <= 1'b0;
                        x_is_load_r <= 1'b0;
                    end
                    wait_cnt_r <= wait_cnt_r + WC_W'(1);
                    if (stall_cnt_r != CNT_MAX) begin
                        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
                    end
                    if (bus.mem_rdata_vld) begin
                        w_data_r <= bus.mem_rdata;
                        w_rdy_r  <= 1'b1;
                        state_r  <= ST_RUN;
                    end else if (timeout_s) begin
                        w_data_r <= 32'd0;
                        w_rdy_r  <= 1'b1;
                        state_r  <= ST_RUN;
                    end else begin
                        state_r  <= ST_LD_WAIT;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

    // Output decode from the state and W-stage registers.
    always_comb begin
        fwd_valid_s   = w_valid_r & w_we_r & w_rdy_r;
        bus.iss_ready = (state_r == ST_RUN);
        stall         = (state_r == ST_LD_WAIT);
        bus.fwd_valid = fwd_valid_s;
        bus.fwd_rd    = w_rd_r;
        bus.fwd_data  = w_data_r;
        // A completed load is ready during its last wait cycle only after the
        // edge, so gating on RUN keeps writeback to exactly one cycle.
        bus.wb_en     = fwd_valid_s & (state_r == ST_RUN);
        bus.wb_rd     = w_rd_r;
        bus.wb_data   = w_data_r;
        ld_timeout    = timeout_s;
        stall_cnt     = stall_cnt_r;
    end

endmodule

// File: tb/tb_fwd_source_tracker.sv
module tb_fwd_source_tracker;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        stall;
    logic        ld_timeout;
    logic [15:0] stall_cnt;
    int          checks = 0;
    int          failures = 0;

    fwd_source_tracker_if bus_if ();

    fwd_source_tracker #(.LD_TIMEOUT(16), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (bus_if),
        .stall      (stall),
        .ld_timeout (ld_timeout),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd);
        return {20'h12345, rd, op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] exr,
                         input logic fl, input logic mv, input logic [31:0] md);
        bus_if.iss_valid     = v;
        bus_if.iss_inst      = inst;
        bus_if.ex_result     = exr;
        flush                = fl;
        bus_if.mem_rdata_vld = mv;
        bus_if.mem_rdata     = md;
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), $urandom);
            checks++;
            if ({bus_if.wb_en, bus_if.fwd_valid, stall, ld_timeout, bus_if.iss_ready} !== 5'b00001) begin
                failures++;
                $display("FAIL reset_ctrl: got %b exp 00001", {bus_if.wb_en, bus_if.fwd_valid, stall, ld_timeout, bus_if.iss_ready});
            end
            checks++;
            if (stall_cnt !== 16'd0 || bus_if.fwd_rd !== 5'd0 || bus_if.fwd_data !== 32'd0) begin
                failures++;
                $display("FAIL reset_regs: cnt=%h rd=%h data=%h exp all 0", stall_cnt, bus_if.fwd_rd, bus_if.fwd_data);
            end
            tick();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        drive(1'b1, mk(OPC_OPIMM, 5'd5), 32'd0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (bus_if.iss_ready !== 1'b1) begin failures++; $display("FAIL alu_ready: got %b exp 1", bus_if.iss_ready); end
        tick();
        drive(1'b0, 32'd0, 32'h0000_1234, 1'b0, 1'b0, 32'd0);
        checks++;
        if (bus_if.wb_en !== 1'b0) begin failures++; $display("FAIL alu_early: wb_en got %b exp 0", bus_if.wb_en); end
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (bus_if.wb_en !== 1'b1 || bus_if.fwd_valid !== 1'b1) begin
            failures++; $display("FAIL alu_wb: wb_en=%b fwd_valid=%b exp 1 1", bus_if.wb_en, bus_if.fwd_valid);
        end
        checks++;
        if (bus_if.fwd_rd !== 5'd5 || bus_if.wb_rd !== 5'd5) begin
            failures++; $display("FAIL alu_rd: fwd_rd=%0d wb_rd=%0d exp 5", bus_if.fwd_rd, bus_if.wb_rd);
        end
        checks++;
        if (bus_if.fwd_data !== 32'h0000_1234 || bus_if.wb_data !== 32'h0000_1234) begin
            failures++; $display("FAIL alu_data: fwd=%h wb=%h exp 00001234", bus_if.fwd_data, bus_if.wb_data);
        end
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (bus_if.wb_en !== 1'b0) begin failures++; $display("FAIL alu_once: wb_en got %b exp 0", bus_if.wb_en); end
        tick();
    endtask

    task automatic test_no_rd();
        logic [31:0] insts [3];
        insts[0] = mk(OPC_STORE, 5'd6);
        insts[1] = mk(OPC_BRANCH, 5'd8);
        insts[2] = mk(OPC_OPIMM, 5'd0);
        for (int i = 0; i < 6; i++) begin
            drive(i < 3, (i < 3) ? insts[i] : 32'd0, 32'hBEEF_0000 + 32'(i), 1'b0, 1'b0, 32'd0);
            checks++;
            if (bus_if.fwd_valid !== 1'b0 || bus_if.wb_en !== 1'b0) begin
                failures++; $display("FAIL no_rd cycle %0d: fwd_valid=%b wb_en=%b exp 0 0", i, bus_if.fwd_valid, bus_if.wb_en);
            end
            tick();
        end
    endtask

    task automatic test_load_wait();
        do_reset();
        drive(1'b1, mk(OPC_LOAD, 5'd7), 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        drive(1'b0, 32'd0, 32'h0000_0100, 1'b0, 1'b0, 32'd0);
        checks++;
        if (stall !== 1'b0 || bus_if.iss_ready !== 1'b1) begin
            failures++; $display("FAIL load_x: stall=%b ready=%b exp 0 1", stall, bus_if.iss_ready);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, mk(OPC_OPIMM, 5'd1), 32'd0, 1'b0, i == 3, (i == 3) ? 32'h0000_CAFE : 32'd0);
            checks++;
            if (stall !== 1'b1 || bus_if.iss_ready !== 1'b0 || bus_if.wb_en !== 1'b0 || ld_timeout !== 1'b0) begin
                failures++;
                $display("FAIL load_wait %0d: stall=%b ready=%b wb_en=%b to=%b exp 1 0 0 0", i, stall, bus_if.iss_ready, bus_if.wb_en, ld_timeout);
            end
            tick();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (stall !== 1'b0 || bus_if.wb_en !== 1'b1 || bus_if.wb_rd !== 5'd7 || bus_if.wb_data !== 32'h0000_CAFE) begin
            failures++;
            $display("FAIL load_wb: stall=%b wb_en=%b rd=%0d data=%h exp 0 1 7 0000cafe", stall, bus_if.wb_en, bus_if.wb_rd, bus_if.wb_data);
        end
        checks++;
        if (stall_cnt !== 16'd4) begin failures++; $display("FAIL load_cnt: got %0d exp 4", stall_cnt); end
        tick();
        // Late data while running must not produce a writeback.
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0000_DEAD);
            checks++;
            if (bus_if.wb_en !== 1'b0 || stall !== 1'b0) begin
                failures++; $display("FAIL load_run_vld %0d: wb_en=%b stall=%b exp 0 0", i, bus_if.wb_en, stall);
            end
            tick();
        end
    endtask

    task automatic test_timeout();
        int pulses;
        pulses = 0;
        drive(1'b1, mk(OPC_LOAD, 5'd3), 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        drive(1'b0, 32'd0, 32'h0000_0200, 1'b0, 1'b0, 32'd0);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
            if (ld_timeout === 1'b1) pulses++;
            checks++;
            if (stall !== 1'b1 || ld_timeout !== (i == 15)) begin
                failures++; $display("FAIL timeout_wait %0d: stall=%b ld_timeout=%b", i, stall, ld_timeout);
            end
            tick();
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (pulses != 1 || ld_timeout !== 1'b0) begin
            failures++; $display("FAIL timeout_pulse: pulses=%0d now=%b exp 1 0", pulses, ld_timeout);
        end
        checks++;
        if (stall !== 1'b0 || bus_if.wb_en !== 1'b1 || bus_if.wb_rd !== 5'd3 || bus_if.wb_data !== 32'd0) begin
            failures++;
            $display("FAIL timeout_wb: stall=%b wb_en=%b rd=%0d data=%h exp 0 1 3 0", stall, bus_if.wb_en, bus_if.wb_rd, bus_if.wb_data);
        end
        checks++;
        if (stall_cnt !== 16'd20) begin failures++; $display("FAIL timeout_cnt: got %0d exp 20", stall_cnt); end
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        checks++;
        if (bus_if.wb_en !== 1'b0) begin failures++; $display("FAIL timeout_once: wb_en got %b exp 0", bus_if.wb_en); end
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, mk(OPC_OPIMM, 5'd1), 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        drive(1'b0, 32'd0, 32'h0000_0011, 1'b0, 1'b0, 32'd0);
        tick();
        drive(1'b1, mk(OPC_OPIMM, 5'd9), 32'd0, 1'b1, 1'b0, 32'd0);
        checks++;
        if (bus_if.wb_en !== 1'b1 || bus_if.wb_rd !== 5'd1 || bus_if.wb_data !== 32'h0000_0011) begin
            failures++; $display("FAIL flush_older: wb_en=%b rd=%0d data=%h exp 1 1 00000011", bus_if.wb_en, bus_if.wb_rd, bus_if.wb_data);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'd0, 32'h0000_0099, 1'b0, 1'b0, 32'd0);
            checks++;
            if (bus_if.wb_en !== 1'b0 || bus_if.fwd_valid !== 1'b0) begin
                failures++; $display("FAIL flush_drop %0d: wb_en=%b fwd_valid=%b rd=%0d exp 0 0", i, bus_if.wb_en, bus_if.fwd_valid, bus_if.wb_rd);
            end
            tick();
        end
    endtask

    task automatic test_flush_ld_wait();
        drive(1'b1, mk(OPC_LOAD, 5'd2), 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        // ADDI x4 issues behind the load, then is flushed while the load waits.
        drive(1'b1, mk(OPC_OPIMM, 5'd4), 32'h0000_0300, 1'b0, 1'b0, 32'd0);
        tick();
        drive(1'b0, 32'd0, 32'h0000_0044, 1'b1, 1'b0, 32'd0);
        tick();
        drive(1'b0, 32'd0, 32'h0000_0044, 1'b0, 1'b1, 32'h0000_0055);
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL flush_ld_stay: stall got %b exp 1", stall); end
        tick();
        drive(1'b0, 32'd0, 32'h0000_0044, 1'b0, 1'b0, 32'd0);
        checks++;
        if (bus_if.wb_en !== 1'b1 || bus_if.wb_rd !== 5'd2 || bus_if.wb_data !== 32'h0000_0055) begin
            failures++; $display("FAIL flush_ld_wb: wb_en=%b rd=%0d data=%h exp 1 2 00000055", bus_if.wb_en, bus_if.wb_rd, bus_if.wb_data);
        end
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
            checks++;
            if (bus_if.wb_en !== 1'b0) begin
                failures++; $display("FAIL flush_ld_x %0d: wb_en=%b rd=%0d exp 0", i, bus_if.wb_en, bus_if.wb_rd);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_load();
        drive(1'b1, mk(OPC_LOAD, 5'd7), 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        drive(1'b0, 32'd0, 32'h0000_0400, 1'b0, 1'b0, 32'd0);
        tick();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0 || bus_if.iss_ready !== 1'b1 || stall_cnt !== 16'd0) begin
            failures++; $display("FAIL rst_mid: stall=%b ready=%b cnt=%0d exp 0 1 0", stall, bus_if.iss_ready, stall_cnt);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'h0000_0077);
            checks++;
            if (bus_if.wb_en !== 1'b0) begin failures++; $display("FAIL rst_mid_wb %0d: wb_en=%b exp 0", i, bus_if.wb_en); end
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
        test_reset();
        test_alu();
        test_no_rd();
        test_load_wait();
        test_timeout();
        test_flush();
        test_flush_ld_wait();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
